// File: rtl/alu_bit_splitter_if.sv
// Handshake bundle for the bit splitter: one mask in, then one serialized one-hot beat out per set bit.
// slave is the splitter's view of the bundle; master is the view of the block driving it.
interface alu_bit_splitter_if #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_onehot;
    logic [IDXW-1:0]  out_index;
    logic             out_last;
    logic             out_zero;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_onehot, out_index, out_last, out_zero
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_onehot, out_index, out_last, out_zero
    );
endinterface

// File: rtl/alu_bit_splitter.sv
// Serializes the set bits of a mask as one-hot words plus index, LSB first (inverse of an OR merge).
// Latency: first beat one cycle after acceptance, then one beat per cycle; a zero mask gives one beat.
// Backpressure: out_ready low freezes the current beat; no new mask is taken until the last beat is accepted.
module alu_bit_splitter #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_bit_splitter_if.slave    bus,
    output logic                 busy
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] rem, rem_nxt;
    logic             zero_flag, zero_flag_nxt;
    logic [WIDTH-1:0] rem_low;
    logic [WIDTH-1:0] rem_rest;
    logic [IDXW-1:0]  low_idx;

    // rem_low isolates the lowest set bit; rem_rest is rem with that bit cleared.
    assign rem_low  = rem & (~rem + WIDTH'(1));
    assign rem_rest = rem & (rem - WIDTH'(1));

    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rem[i]) low_idx = IDXW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rem       <= '0;
            zero_flag <= 1'b0;
        end else begin
            state     <= state_nxt;
            rem       <= rem_nxt;
            zero_flag <= zero_flag_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        rem_nxt        = rem;
        zero_flag_nxt  = zero_flag;
        bus.in_ready   = 1'b0;
        bus.out_valid  = 1'b0;
        bus.out_onehot = '0;
        bus.out_index  = '0;
        bus.out_last   = 1'b0;
        bus.out_zero   = 1'b0;
        busy           = 1'b0;

        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    rem_nxt       = bus.in_data;
                    zero_flag_nxt = (bus.in_data == '0);
                    state_nxt     = EMIT;
                end
            end
            EMIT: begin
                bus.out_valid  = 1'b1;
                busy           = 1'b1;
                bus.out_onehot = rem_low;
                bus.out_index  = low_idx;
                bus.out_last   = (rem_rest == '0);
                bus.out_zero   = zero_flag;
                if (bus.out_ready) begin
                    if (rem_rest == '0) begin
                        state_nxt     = IDLE;
                        rem_nxt       = '0;
                        zero_flag_nxt = 1'b0;
                    end else begin
                        rem_nxt = rem_rest;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_alu_bit_splitter.sv
// Bench for alu_bit_splitter: directed mask table, backpressure and mid-mask reset sequences, random masks.
module tb_alu_bit_splitter;
    localparam int WIDTH = 32;
    localparam int IDXW  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_bit_splitter_if #(.WIDTH(WIDTH), .IDXW(IDXW)) bus ();

    alu_bit_splitter #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    typedef struct {
        logic [31:0] mask;
        int          beats;
        int          first;
        int          fin;
        int          low;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // mode 0: out_ready always 1; mode 1: random; mode 2: pattern 0,0,1,0,1 then 1.
    task automatic run_mask(input logic [31:0] mask, input int mode,
                            output int beats, output logic [31:0] or_acc,
                            output int first_idx, output int final_idx, output int low_cyc);
        int          prev_model;
        int          prev_act;
        bit          done;
        bit          held;
        bit          rdy;
        int          cyc;
        int          pat_i;
        int          pat[5];
        int          nxt;
        logic [31:0] p_oh;
        logic [4:0]  p_idx;
        logic        p_last;
        logic        p_zero;
        logic [31:0] exp_oh;
        logic [31:0] exp_idx;
        logic        exp_last;
        pat = '{0, 0, 1, 0, 1};
        beats = 0; or_acc = '0; first_idx = -1; final_idx = -1; low_cyc = 0;
        prev_model = -1; prev_act = -1; done = 0; held = 0; pat_i = 0;
        p_oh = '0; p_idx = '0; p_last = 0; p_zero = 0;
        check("accept_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = mask;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        cyc = 0;
        while (!done && cyc < 200) begin
            cyc++;
            if (!bus.in_ready) low_cyc++;
            if (held) begin
                check("hold_onehot", bus.out_onehot, p_oh);
                check("hold_index", {27'd0, bus.out_index}, {27'd0, p_idx});
                check("hold_last", {31'd0, bus.out_last}, {31'd0, p_last});
                check("hold_zero", {31'd0, bus.out_zero}, {31'd0, p_zero});
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(3) != 0);
                default: rdy = (pat_i < 5) ? (pat[pat_i] != 0) : 1'b1;
            endcase
            pat_i++;
            bus.out_ready = rdy;
            if (bus.out_valid) begin
                check("busy_emit", {31'd0, busy}, 32'd1);
                if (rdy) begin
                    nxt = -1;
                    for (int i = prev_model + 1; i < 32; i++)
                        if (mask[i] && nxt < 0) nxt = i;
                    if (mask == 0) begin
                        if (beats != 0) check("extra_beat", beats, 0);
                        exp_oh = '0; exp_idx = '0; exp_last = 1'b1;
                    end else if (nxt < 0) begin
                        check("extra_beat", beats, $countones(mask));
                        exp_oh = '0; exp_idx = '0; exp_last = 1'b1;
                    end else begin
                        exp_oh   = 32'd1 << nxt;
                        exp_idx  = nxt;
                        exp_last = ((mask >> (nxt + 1)) == 0);
                        prev_model = nxt;
                    end
                    check("beat_onehot", bus.out_onehot, exp_oh);
                    check("beat_index", {27'd0, bus.out_index}, exp_idx);
                    check("beat_last", {31'd0, bus.out_last}, {31'd0, exp_last});
                    check("beat_zero", {31'd0, bus.out_zero}, {31'd0, (mask == 0)});
                    if (mask != 0) check("ascending", {31'd0, (int'(bus.out_index) > prev_act)}, 32'd1);
                    prev_act = int'(bus.out_index);
                    or_acc |= bus.out_onehot;
                    beats++;
                    if (first_idx < 0) first_idx = int'(bus.out_index);
                    final_idx = int'(bus.out_index);
                    if (bus.out_last) done = 1;
                end
                held   = !rdy;
                p_oh   = bus.out_onehot;
                p_idx  = bus.out_index;
                p_last = bus.out_last;
                p_zero = bus.out_zero;
            end else begin
                held = 0;
            end
            @(posedge clk); @(negedge clk);
        end
        if (!done) check("timeout", 32'd0, 32'd1);
        check("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        int          beats;
        logic [31:0] or_acc;
        int          first_idx;
        int          final_idx;
        int          low_cyc;
        logic [31:0] m;

        tbl[0] = '{32'h0000_0005,  2,  0,  2,  2};
        tbl[1] = '{32'h0000_0000,  1,  0,  0,  1};
        tbl[2] = '{32'hFFFF_FFFF, 32,  0, 31, 32};
        tbl[3] = '{32'h8000_0001,  2,  0, 31,  2};
        tbl[4] = '{32'h0001_0000,  1, 16, 16,  1};
        tbl[5] = '{32'h4000_0000,  1, 30, 30,  1};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_last", {31'd0, bus.out_last}, 32'd0);
        check("rst_out_zero", {31'd0, bus.out_zero}, 32'd0);
        check("rst_out_onehot", bus.out_onehot, 32'd0);
        check("rst_out_index", {27'd0, bus.out_index}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        for (int v = 0; v < 6; v++) begin
            run_mask(tbl[v].mask, 0, beats, or_acc, first_idx, final_idx, low_cyc);
            check("tbl_beats", beats, tbl[v].beats);
            check("tbl_or", or_acc, tbl[v].mask);
            check("tbl_first", first_idx, tbl[v].first);
            check("tbl_final", final_idx, tbl[v].fin);
            check("tbl_in_ready_low", low_cyc, tbl[v].low);
        end

        run_mask(32'h8000_0010, 2, beats, or_acc, first_idx, final_idx, low_cyc);
        check("bp_beats", beats, 2);
        check("bp_or", or_acc, 32'h8000_0010);
        check("bp_first", first_idx, 4);
        check("bp_final", final_idx, 31);
        check("bp_in_ready_low", low_cyc, 5);

        // Reset in the middle of 0x0000F000, after beats at index 12 and 13.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h0000_F000;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        check("rmid_beat1", {27'd0, bus.out_index}, 32'd12);
        @(posedge clk); @(negedge clk);
        check("rmid_beat2", {27'd0, bus.out_index}, 32'd13);
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        check("rmid_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rmid_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rmid_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); @(negedge clk);
        check("rmid_no_more", {31'd0, bus.out_valid}, 32'd0);
        run_mask(32'h0000_0002, 0, beats, or_acc, first_idx, final_idx, low_cyc);
        check("rmid_new_beats", beats, 1);
        check("rmid_new_index", final_idx, 1);

        for (int k = 0; k < 1000; k++) begin
            m = (k % 50 == 0) ? 32'd0 : ($urandom & $urandom);
            run_mask(m, 1, beats, or_acc, first_idx, final_idx, low_cyc);
            check("rnd_beats", beats, (m == 0) ? 1 : $countones(m));
            check("rnd_or", or_acc, m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
